// File: rtl/tt_pll_pkg.sv
// tt_pll_pkg: shared types and defaults for the ADPLL digital blocks.
// Imported by tt_pfd and by the loop filter.
package tt_pll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } pfd_state_e;

    localparam int PFD_CNT_W     = 8;
    localparam int PFD_MAX_PULSE = 200;
    localparam int CTRL_W        = 16;

endpackage

// File: rtl/tt_sync_edge.sv
// tt_sync_edge: multi-flop synchronizer, history flop and rising-edge pulse.
// One instance per asynchronous PFD input.
module tt_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk_gen,
    input  logic i_rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/tt_pfd.sv
// tt_pfd: digital phase-frequency detector feeding the ADPLL loop filter.
// Define TT_PFD_LOCK_DET_EN to build the pulse-length lock detector.
module tt_pfd
    import tt_pll_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = PFD_CNT_W,
    parameter int MAX_PULSE   = PFD_MAX_PULSE,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic i_clk_gen,
    input  logic i_rst_n,
    input  logic i_ref_clk,
    input  logic i_fb_clk,
    output logic o_up,
    output logic o_down,
    output logic o_lock,
    input  logic i_scan_en,
    input  logic i_scan_in,
    output logic o_scan_out
);

    if (SYNC_STAGES < 2 || MAX_PULSE < 1 || MAX_PULSE >= (1 << CNT_W) ||
        LOCK_TOL < 0 || LOCK_COUNT < 1) begin : g_bad_cfg
        $error("tt_pfd: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PULSE - 1);

    pfd_state_e       state;
    pfd_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ref_rise;
    logic             fb_rise;
    logic             active;
    logic             timeout;
    logic             up_q;
    logic             down_q;

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .i_clk_gen (i_clk_gen),
        .i_rst_n   (i_rst_n),
        .async_in  (i_ref_clk),
        .rise      (ref_rise)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .i_clk_gen (i_clk_gen),
        .i_rst_n   (i_rst_n),
        .async_in  (i_fb_clk),
        .rise      (fb_rise)
    );

    assign active  = (state == UP) || (state == DOWN);
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Count hits MAX_PULSE on the same edge that drops the FSM to IDLE.
    assign timeout = active && (cnt >= CNT_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_scan_en) begin
            cnt_nxt   = {cnt[CNT_W-2:0], i_scan_in};
            state_nxt = pfd_state_e'({state[0], cnt[CNT_W-1]});
        end else begin
            unique case (state)
                IDLE: begin
                    if (ref_rise && !fb_rise) begin
                        state_nxt = UP;
                    end else if (fb_rise && !ref_rise) begin
                        state_nxt = DOWN;
                    end
                end
                UP: begin
                    if (timeout || fb_rise) begin
                        state_nxt = IDLE;
                    end
                end
                DOWN: begin
                    if (timeout || ref_rise) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (state == IDLE && state_nxt != IDLE) begin
                cnt_nxt = '0;
            end else if (active) begin
                cnt_nxt = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            up_q   <= (state == UP);
            down_q <= (state == DOWN);
        end
    end

    assign o_up       = up_q & ~i_scan_en;
    assign o_down     = down_q & ~i_scan_en;
    assign o_scan_out = state[1];

`ifdef TT_PFD_LOCK_DET_EN
    localparam int                LOCK_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

    logic [LOCK_W-1:0] lock_cnt;
    logic [CNT_W-1:0]  last_len;
    logic              pulse_seen;
    logic              pulse_end;
    logic              in_tol;

    // A pulse closing on the same edge as ref_rise is the one scored.
    assign pulse_end = ~i_scan_en & active & (state_nxt == IDLE);

    always_comb begin
        in_tol = 1'b1;
        if (pulse_end) begin
            in_tol = (cnt_inc <= CNT_W'(LOCK_TOL));
        end else if (pulse_seen) begin
            in_tol = (last_len <= CNT_W'(LOCK_TOL));
        end
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_cnt   <= '0;
            last_len   <= '0;
            pulse_seen <= 1'b0;
        end else if (!i_scan_en) begin
            if (pulse_end) begin
                last_len   <= cnt_inc;
                pulse_seen <= 1'b1;
            end
            if (ref_rise) begin
                pulse_seen <= 1'b0;
            end
            if (pulse_end && timeout) begin
                lock_cnt <= '0;
            end else if (ref_rise && !in_tol) begin
                lock_cnt <= '0;
            end else if (ref_rise && lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end
        end
    end

    assign o_lock = (lock_cnt == LOCK_MAX);
`else
    assign o_lock = 1'b0;
`endif

endmodule
